data_memory_param: RTL and testbench

//  Parametrised single-port data memory: next generation of the 4x16 datapath RAM.

---
 rtl/data_mem_pkg.sv | 15 +
 rtl/data_memory_param_mem_init_seq.sv | 62 ++++++
 rtl/data_memory_param.sv | 128 ++++++++++++
 tb/tb_data_memory_param.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the parametrised data memory.
//   mem_state_t : init-sequencer state (INIT fills the array, IDLE serves accesses)
//   INIT_ZERO   : init sequence writes 0 to every word
//   INIT_INDEX  : init sequence writes the word's own index (zero-extended/truncated)
package data_mem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } mem_state_t;

    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;

endpackage

// File: rtl/data_memory_param_mem_init_seq.sv
// Hardware init sequencer: walks every word address once after reset or after
// an init_req pulse seen in IDLE, presenting one init write per clock.
//   clk, reset_n : clock, synchronous active-low reset (restarts the sequence)
//   init_req     : 1-cycle pulse, honoured only in IDLE
//   busy         : sequence running (high for exactly 2**ADDR_W cycles)
//   init_we      : write strobe for the storage array
//   init_addr    : word currently being initialised
//   init_data    : value for that word, chosen by INIT_MODE
module mem_init_seq
    import data_mem_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 4,
    parameter int INIT_MODE = INIT_INDEX
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              init_req,
    output logic              busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data
);

    // Explicit last-word compare keeps cnt at ADDR_W bits without wrapping into a second pass.
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    mem_state_t        state_q;
    logic [ADDR_W-1:0] cnt_q;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else if (state_q == INIT) begin
            if (cnt_q == LAST_ADDR) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + ADDR_W'(1);
            end
        end else if (init_req) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end
    end

    assign busy      = (state_q == INIT);
    assign init_we   = busy;
    assign init_addr = cnt_q;

    generate
        if (INIT_MODE == INIT_INDEX) begin : g_init_index
            // Size cast truncates when DATA_W < ADDR_W and zero-extends otherwise.
            assign init_data = DATA_W'(cnt_q);
        end else begin : g_init_zero
            assign init_data = '0;
        end
    endgenerate

endmodule

// File: rtl/data_memory_param.sv
// Parametrised single-port data memory with hardware init and optional read register.
//   clk, reset_n : clock, synchronous active-low reset (restarts init)
//   M_add        : word address shared by read and write
//   M_wd, M_we   : write data / write enable
//   M_re         : read enable
//   init_req     : 1-cycle pulse re-running the init sequence (IDLE only)
//   M_rd         : read data, 0 when no valid read
//   M_rvalid     : M_rd holds valid read data
//   busy         : init running, user accesses ignored
//   access_err   : 1-cycle pulse after an access attempted while busy
module data_memory_param
    import data_mem_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 4,
    parameter int INIT_MODE = INIT_INDEX,
    parameter int READ_LAT  = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] M_add,
    input  logic [DATA_W-1:0] M_wd,
    input  logic              M_we,
    input  logic              M_re,
    input  logic              init_req,
    output logic [DATA_W-1:0] M_rd,
    output logic              M_rvalid,
    output logic              busy,
    output logic              access_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_ok;
    logic              access_err_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    mem_init_seq #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_MODE (INIT_MODE)
    ) u_init_seq (
        .clk       (clk),
        .reset_n   (reset_n),
        .init_req  (init_req),
        .busy      (busy),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    // User accesses are accepted only in IDLE, and a same-cycle init_req takes priority.
    assign rd_ok = !busy && !init_req && M_re;

    // Write-port mux: sequencer owns the port while busy. Writes are suppressed
    // in the reset cycle because the restarted init will overwrite every word anyway.
    // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = M_add;
        wr_data = M_wd;
        if (busy) begin
            wr_en   = init_we;
            wr_addr = init_addr;
            wr_data = init_data;
        end else begin
            wr_en = M_we && !init_req;
        end
        if (!reset_n) begin
            wr_en = 1'b0;
        end
    end

    // NOTE: the storage array has no reset; the init sequencer defines its contents instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            access_err_q <= 1'b0;
        end else begin
            access_err_q <= busy && (M_we || M_re);
        end
    end

    assign access_err = access_err_q;

    generate
        if (READ_LAT == 0) begin : g_read_comb
            // Array is read before the edge, so a same-cycle write returns the old word.
            assign M_rvalid = rd_ok;
            assign M_rd     = rd_ok ? mem_q[M_add] : '0;
        end else begin : g_read_reg
            logic [DATA_W-1:0] rd_q;
            logic              rvalid_q;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    rd_q     <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_ok;
                    if (rd_ok) begin
                        // Write-first: rd_ok implies the same-cycle write is accepted.
                        rd_q <= M_we ? M_wd : mem_q[M_add];
                    end else begin
                        rd_q <= '0;
                    end
                end
            end

            assign M_rd     = rd_q;
            assign M_rvalid = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_data_memory_param.sv
// Bench for data_memory_param: one combinational-read and one registered-read
// instance share the same stimulus and are compared against a word-array model.
module tb_data_memory_param;

    logic       clk;
    logic       reset_n;
    logic [3:0] M_add;
    logic [3:0] M_wd;
    logic       M_we;
    logic       M_re;
    logic       init_req;

    logic [3:0] rd0, rd1;
    logic       v0, v1, busy0, busy1, err0, err1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: word contents, remaining init cycles, and next registered outputs.
    logic [3:0] m_mem [16];
    int         init_left;
    logic       m_err;
    logic [3:0] m_rd1;
    logic       m_v1;

    data_memory_param dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .M_add      (M_add),
        .M_wd       (M_wd),
        .M_we       (M_we),
        .M_re       (M_re),
        .init_req   (init_req),
        .M_rd       (rd0),
        .M_rvalid   (v0),
        .busy       (busy0),
        .access_err (err0)
    );

    data_memory_param #(.READ_LAT(1)) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .M_add      (M_add),
        .M_wd       (M_wd),
        .M_we       (M_we),
        .M_re       (M_re),
        .init_req   (init_req),
        .M_rd       (rd1),
        .M_rvalid   (v1),
        .busy       (busy1),
        .access_err (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, check mid-cycle against the model, advance model, cross the edge.
    task automatic step(input logic we, input logic re, input logic ir, input logic rn,
                        input logic [3:0] a, input logic [3:0] d,
                        input bit lit_en = 1'b0, input logic [3:0] lit = 4'h0,
                        input string tag = "");
        logic       busy_e;
        logic       v0_e;
        logic [3:0] rd0_e;
        M_we     = we;
        M_re     = re;
        init_req = ir;
        reset_n  = rn;
        M_add    = a;
        M_wd     = d;
        @(negedge clk);
        busy_e = (init_left > 0);
        v0_e   = !busy_e && re && !ir;
        rd0_e  = v0_e ? m_mem[a] : 4'h0;
        check("busy0", busy0, busy_e);
        check("busy1", busy1, busy_e);
        check("rvalid0", v0, v0_e);
        check("rd0", rd0, rd0_e);
        check("access_err0", err0, m_err);
        check("access_err1", err1, m_err);
        check("rvalid1", v1, m_v1);
        check("rd1", rd1, m_rd1);
        if (lit_en) check(tag, rd0, lit);
        if (!rn) begin
            init_left = 16;
            m_err = 1'b0;
            m_rd1 = 4'h0;
            m_v1  = 1'b0;
        end else if (busy_e) begin
            m_mem[16 - init_left] = 4'(16 - init_left);
            init_left--;
            m_err = we || re;
            m_rd1 = 4'h0;
            m_v1  = 1'b0;
        end else begin
            m_err = 1'b0;
            if (ir) begin
                init_left = 16;
                m_rd1 = 4'h0;
                m_v1  = 1'b0;
            end else begin
                if (we) m_mem[a] = d;
                m_v1  = re;
                m_rd1 = re ? m_mem[a] : 4'h0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    endtask

    initial begin
        int n_busy;
        init_left = 16;
        m_err = 1'b0;
        m_rd1 = 4'h0;
        m_v1  = 1'b0;

        // Reset, then the full 16-cycle init.
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        check("busy_after_reset", busy0, 1'b1);
        check("rvalid_after_reset", v1, 1'b0);
        repeat (16) idle();
        check("busy_fall", busy0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 4'h0, 1'b1, 4'h9, "rd_addr9");

        // Write then read back; neighbour untouched.
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 4'hA);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 4'h0, 1'b1, 4'hA, "rd_after_wr");
        check("rl1_rd_after_wr", rd1, 4'hA);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h4, 4'h0, 1'b1, 4'h4, "rd_addr4");

        // Accesses while busy are flagged and have no effect.
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 4'hF);
        check("access_err_pulse", err0, 1'b1);
        idle();
        check("access_err_clear", err0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h7, 4'h0);
        check("access_err_on_read", err1, 1'b1);
        repeat (13) idle();
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 4'h0, 1'b1, 4'h3, "rd_after_reinit");

        // init_req wins over a same-cycle write.
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 4'hC);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 4'h3);
        check("no_read_on_init_req", v1, 1'b0);
        repeat (16) idle();
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 4'h0, 1'b1, 4'h5, "wr_dropped_by_init_req");

        // Same-cycle write and read of one address: old data combinational, new data registered.
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'h2, 4'h7, 1'b1, 4'h2, "rl0_old_data");
        check("rl1_write_first", rd1, 4'h7);
        check("rl1_valid", v1, 1'b1);

        // Reset at init cycle 8 restarts a full init.
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
        repeat (8) idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        n_busy = 0;
        while (busy0 === 1'b1 && n_busy < 40) begin
            idle();
            n_busy++;
        end
        check("reset_restart_len", n_busy, 16);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 4'h0, 1'b1, 4'h2, "rd_after_restart");

        // Random traffic with occasional re-init and reset.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 199) != 0),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
